// File: rtl/dense_stream_pkg.sv
// Shared defaults and read-side state encoding for the dense-layer feature streamer.
package dense_stream_pkg;

  localparam int DATA_WIDTH_DEF  = 21;
  localparam int ROWS_DEF        = 24;
  localparam int COORD_WIDTH_DEF = 5;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

endpackage

// File: rtl/feature_bank.sv
// One frame buffer: ROWS x DATA_WIDTH, synchronous write, asynchronous read.
module feature_bank
  import dense_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ROWS       = ROWS_DEF,
  localparam int AW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk_in,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [ROWS];

  // Storage is not reset; the owning full flag decides whether contents are meaningful.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/feature_streamer.sv
// Ping-pong row buffer between the feature extractor and the dense layer.
// Read FSM:
//   state     | meaning
//   RD_IDLE   | no beat presented; waiting for the read bank to fill
//   RD_STREAM | a registered beat is presented; advances on each accepted row
module feature_streamer
  import dense_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ROWS        = ROWS_DEF,
  parameter int COORD_WIDTH = COORD_WIDTH_DEF
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   wr_valid_in,
  input  logic [DATA_WIDTH-1:0]  wr_data_in,
  input  logic                   wr_last_in,
  output logic                   wr_ready_out,
  input  logic                   rd_ready_in,
  output logic                   data_valid_out,
  output logic [DATA_WIDTH-1:0]  pixel_data_out,
  output logic [COORD_WIDTH-1:0] vcount_out,
  output logic [COORD_WIDTH-1:0] hcount_out,
  output logic                   frame_done_out,
  output logic                   error_out
);

  localparam int            AW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  logic [1:0]            full;
  logic [1:0]            full_set;
  logic [1:0]            full_clr;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [AW-1:0]         wr_row;
  logic [AW-1:0]         rd_row;

  logic                  wr_take;
  logic                  wr_at_end;
  logic                  wr_done;
  logic                  wr_err;

  rd_state_t             state;
  rd_state_t             state_nxt;
  logic                  load;
  logic                  load_sel;
  logic [AW-1:0]         load_row;
  logic                  release_bank;
  logic                  valid_nxt;
  logic                  other_full;
  logic [DATA_WIDTH-1:0] bank0_rd_data;
  logic [DATA_WIDTH-1:0] bank1_rd_data;
  logic [DATA_WIDTH-1:0] load_data;

  assign wr_ready_out = ~full[wr_bank];
  assign wr_take      = wr_valid_in & wr_ready_out;
  assign wr_at_end    = (wr_row == LAST_ROW);
  assign wr_done      = wr_take & wr_at_end & wr_last_in;
  assign wr_err       = wr_take & (wr_at_end ^ wr_last_in);

  feature_bank #(.DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS)) u_bank0 (
    .clk_in  (clk_in),
    .wr_en   (wr_take & ~wr_bank),
    .wr_addr (wr_row),
    .wr_data (wr_data_in),
    .rd_addr (load_row),
    .rd_data (bank0_rd_data)
  );

  feature_bank #(.DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS)) u_bank1 (
    .clk_in  (clk_in),
    .wr_en   (wr_take & wr_bank),
    .wr_addr (wr_row),
    .wr_data (wr_data_in),
    .rd_addr (load_row),
    .rd_data (bank1_rd_data)
  );

  assign load_data = load_sel ? bank1_rd_data : bank0_rd_data;

  // A bank completing this very cycle counts as full so the next frame follows without a bubble.
  assign other_full = full[~rd_bank] | (wr_done & (wr_bank != rd_bank));

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    load_sel     = rd_bank;
    load_row     = '0;
    release_bank = 1'b0;
    valid_nxt    = data_valid_out;
    case (state)
      RD_IDLE: begin
        if (full[rd_bank]) begin
          state_nxt = RD_STREAM;
          load      = 1'b1;
          valid_nxt = 1'b1;
        end
      end
      RD_STREAM: begin
        if (data_valid_out && rd_ready_in) begin
          if (rd_row == LAST_ROW) begin
            release_bank = 1'b1;
            if (other_full) begin
              load     = 1'b1;
              load_sel = ~rd_bank;
            end else begin
              state_nxt = RD_IDLE;
              valid_nxt = 1'b0;
            end
          end else begin
            load     = 1'b1;
            load_row = rd_row + 1'b1;
          end
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  // Set and clear never target the same bank: writes go to an empty bank, releases to a full one.
  assign full_set = wr_done ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr = release_bank ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      full      <= 2'b00;
      wr_bank   <= 1'b0;
      wr_row    <= '0;
      error_out <= 1'b0;
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (wr_done) begin
        wr_row  <= '0;
        wr_bank <= ~wr_bank;
      end else if (wr_err) begin
        wr_row    <= '0;
        error_out <= 1'b1;
      end else if (wr_take) begin
        wr_row <= wr_row + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= RD_IDLE;
      rd_bank        <= 1'b0;
      rd_row         <= '0;
      data_valid_out <= 1'b0;
      pixel_data_out <= '0;
      hcount_out     <= '0;
      frame_done_out <= 1'b0;
    end else begin
      state          <= state_nxt;
      data_valid_out <= valid_nxt;
      frame_done_out <= release_bank;
      if (load) begin
        pixel_data_out <= load_data;
        rd_row         <= load_row;
      end
      if (release_bank) begin
        rd_bank    <= ~rd_bank;
        hcount_out <= hcount_out + 1'b1;
      end
    end
  end

  assign vcount_out = COORD_WIDTH'(rd_row);

endmodule
